// File: rtl/int_ctrl.sv
// Single-level interrupt controller: edge-detected requests, maskable, fixed
// lowest-index priority, and a one-cycle save/restore handshake with the status register.
module int_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq,
    input  logic       mask_we,
    input  logic [3:0] mask_din,
    input  logic       instr_done,
    input  logic       reti,
    output logic       int_save,
    output logic       int_load,
    output logic       flag_we,
    output logic       vec_valid,
    output logic [7:0] vec_addr,
    output logic       in_service,
    output logic [1:0] active_id
);

    typedef enum logic [1:0] {IDLE, SAVE, SERVICE, RESTORE} state_t;

    state_t     state_q, state_d;
    logic [3:0] irq_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] active_q, active_d;

    logic [3:0] irq_rise;
    logic [3:0] req;
    logic [3:0] clr;
    logic [1:0] sel;
    logic       take;

    assign irq_rise = irq & ~irq_q;
    // The take decision sees the mask as it was before any write this cycle.
    assign req      = pending_q & mask_q;
    assign take     = (state_q == IDLE) && instr_done && (|req);

    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) sel = 2'(i);
        end
    end

    always_comb begin
        clr       = take ? (4'b0001 << sel) : 4'b0000;
        // A new edge beats a clear of the same bit.
        pending_d = (pending_q & ~clr) | irq_rise;
        mask_d    = mask_we ? mask_din : mask_q;
        active_d  = take ? sel : active_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = SAVE;
            SAVE:    state_d = SERVICE;
            SERVICE: if (reti) state_d = RESTORE;
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // irq_q resets high so lines already asserted at reset do not look like edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_q     <= 4'b1111;
            pending_q <= 4'b0000;
            mask_q    <= 4'b0000;
            active_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        int_save   = (state_q == SAVE);
        int_load   = (state_q == RESTORE);
        flag_we    = int_save | int_load;
        vec_valid  = int_save;
        in_service = (state_q != IDLE);
        active_id  = active_q;
        vec_addr   = VEC_BASE + {4'b0000, active_q, 2'b00};
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: stimulus pushes expected save/load events into a
// queue, a negedge monitor pops and compares whenever the DUT pulses.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       instr_done;
    logic       reti;
    logic       int_save, int_load, flag_we, vec_valid, in_service;
    logic [7:0] vec_addr;
    logic [1:0] active_id;

    int_ctrl #(.VEC_BASE(8'h10)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_din(mask_din),
        .instr_done(instr_done), .reti(reti), .int_save(int_save), .int_load(int_load),
        .flag_we(flag_we), .vec_valid(vec_valid), .vec_addr(vec_addr),
        .in_service(in_service), .active_id(active_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_save;
        logic [7:0] addr;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errs    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pulse-consistency every cycle, scoreboard pop on each save/load pulse.
    always @(negedge clk) begin
        if (!rst) begin
            chk("flag_we_eq_save_or_load", 32'(flag_we), 32'(int_save | int_load));
            chk("vec_valid_eq_save", 32'(vec_valid), 32'(int_save));
            if (int_save || int_load) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse_save_load", {30'd0, int_save, int_load}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind_save", 32'(int_save), 32'(e.is_save));
                    chk("pulse_kind_load", 32'(int_load), 32'(!e.is_save));
                    chk("in_service_pulse", 32'(in_service), 32'd1);
                    if (e.is_save) begin
                        chk("vec_addr", 32'(vec_addr), 32'(e.addr));
                        chk("active_id", 32'(active_id), 32'(e.id));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_din = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic take(input logic [1:0] id, input logic [7:0] addr);
        exp_t e;
        e.is_save = 1'b1;
        e.addr = addr;
        e.id = id;
        exp_q.push_back(e);
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        tick();
        chk("in_service_in_service_state", 32'(in_service), 32'd1);
    endtask

    task automatic ret();
        exp_t e;
        e.is_save = 1'b0;
        e.addr = 8'h00;
        e.id = 2'd0;
        exp_q.push_back(e);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();
        chk("in_service_after_restore", 32'(in_service), 32'd0);
    endtask

    task automatic idle_boundaries(input int n);
        for (int i = 0; i < n; i++) begin
            instr_done = 1'b1;
            tick();
            instr_done = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; irq = 4'b0000; mask_we = 1'b0; mask_din = 4'b0000;
        instr_done = 1'b0; reti = 1'b0;
        do_reset();
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_vec_addr", 32'(vec_addr), 32'h10);
        chk("rst_active_id", 32'(active_id), 32'd0);
        chk("rst_int_save", 32'(int_save), 32'd0);
        chk("rst_int_load", 32'(int_load), 32'd0);
        chk("rst_flag_we", 32'(flag_we), 32'd0);

        // Single request on irq[2]
        set_mask(4'b1111);
        irq = 4'b0100; tick();
        take(2'd2, 8'h18);
        ret();

        // Simultaneous irq[1]/irq[3]: priority then the remaining one
        irq = 4'b0000; tick();
        irq = 4'b1010; tick();
        take(2'd1, 8'h14);
        ret();
        take(2'd3, 8'h1C);
        ret();

        // Masked request stays pending until unmasked
        set_mask(4'b0000);
        irq = 4'b0000; tick();
        irq = 4'b0001; tick();
        idle_boundaries(3);
        set_mask(4'b0001);
        take(2'd0, 8'h10);
        ret();

        // New edge and boundaries during service are deferred, then re-entry at once
        set_mask(4'b1111);
        irq = 4'b0000; tick();
        irq = 4'b0100; tick();
        take(2'd2, 8'h18);
        irq = 4'b0101; tick();
        idle_boundaries(2);
        ret();
        take(2'd0, 8'h10);
        ret();

        // Reset during service: no load, pending cleared, stray reti ignored
        irq = 4'b0000; tick();
        irq = 4'b0010; tick();
        take(2'd1, 8'h14);
        irq = 4'b0011; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_in_service", 32'(in_service), 32'd0);
        chk("abort_active_id", 32'(active_id), 32'd0);
        chk("abort_int_load", 32'(int_load), 32'd0);
        reti = 1'b1; tick(); reti = 1'b0; tick();
        set_mask(4'b1111);
        idle_boundaries(2);

        // Lines held high through reset never request
        irq = 4'b1111;
        do_reset();
        set_mask(4'b1111);
        idle_boundaries(3);

        tick(); tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: VEC_BASE, 8'h10, base of the interrupt vector table.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: irq  in  4  interrupt request lines; a rising edge on irq[i] is a request.
REQ-005 Port: mask_we  in  1  write strobe for the mask register.
REQ-006 Port: mask_din  in  4  new mask value; bit i = 1 enables irq[i].
REQ-007 Port: instr_done  in  1  CPU pulse marking an instruction boundary.
REQ-008 Port: reti  in  1  CPU pulse when a return-from-interrupt instruction executes.
REQ-009 Port: int_save  out  1  one-cycle pulse; status register saves flags and clears them.
REQ-010 Port: int_load  out  1  one-cycle pulse; status register restores the saved flags.
REQ-011 Port: flag_we  out  1  status register write enable; high in every int_save or int_load cycle, low otherwise.
REQ-012 Port: vec_valid  out  1  one-cycle pulse; vec_addr is the jump target.
REQ-013 Port: vec_addr  out  8  vector address, VEC_BASE + {active_id, 2'b00}, modulo 256.
REQ-014 Port: in_service  out  1  high while a handler is active (SAVE through RESTORE).
REQ-015 Port: active_id  out  2  index of the interrupt being serviced.

Function
REQ-016 SHALL register irq into irq_q every cycle; edge[i] = irq[i] & ~irq_q[i].
REQ-017 SHALL set pending[i] on edge[i], including during SERVICE; set wins over a clear of the same bit in the same cycle.
REQ-018 SHALL load mask from mask_din on mask_we; the take decision in that cycle uses the old mask.
REQ-019 SHALL implement FSM states IDLE, SAVE, SERVICE, RESTORE.
REQ-020 IDLE->SAVE when instr_done=1 and (pending & mask) != 0; otherwise remain in IDLE.
REQ-021 SHALL select the lowest set index of (pending & mask) as highest priority, latch it into active_id, and clear that pending bit on the IDLE->SAVE transition.
REQ-022 SAVE lasts exactly 1 cycle: int_save=1, flag_we=1, vec_valid=1, vec_addr valid; then SERVICE.
REQ-023 SERVICE: wait for reti=1, then RESTORE; ignore instr_done and new requests. Nesting is not supported because the flag save slot is single-depth.
REQ-024 RESTORE lasts exactly 1 cycle: int_load=1, flag_we=1; then IDLE.
REQ-025 Latency: instr_done sampled high in IDLE -> int_save high in the next cycle. reti in SERVICE -> int_load high in the next cycle.
REQ-026 Earliest re-entry: the first IDLE cycle after RESTORE may take a request if instr_done=1 in that cycle.
REQ-027 reti outside SERVICE SHALL be ignored; instr_done outside IDLE SHALL be ignored.
REQ-028 int_save and int_load SHALL never be high in the same cycle.
REQ-029 Masked pending bits SHALL stay pending and SHALL be taken once unmasked at a later boundary.
REQ-030 in_service = 1 in SAVE, SERVICE and RESTORE; 0 in IDLE.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, pending=0, mask=0, active_id=0, irq_q=4'b1111, all pulse outputs=0, in_service=0, vec_addr=VEC_BASE.
REQ-032 irq lines held high through reset SHALL NOT create a request; a line must go low and then high again.
REQ-033 rst during SAVE/SERVICE/RESTORE SHALL abort to IDLE without an int_load pulse.
REQ-034 rst has priority over every other input in the same cycle.

Verification
REQ-035 mask=4'b1111, rising edge on irq[2], instr_done pulse -> next cycle int_save=flag_we=vec_valid=1, vec_addr=8'h18, active_id=2.
REQ-036 Edges on irq[1] and irq[3] in the same cycle, then boundary -> active_id=1, vec_addr=8'h14; after reti -> int_load pulse; at the next boundary active_id=3, vec_addr=8'h1C.
REQ-037 mask=4'b0000, edge on irq[0], 3 boundaries -> no int_save; write mask=4'b0001, next boundary -> int_save, vec_addr=8'h10.
REQ-038 In SERVICE, edge on irq[0] plus instr_done pulses -> no int_save until after RESTORE; reti -> exactly one int_load, with flag_we high in the same cycle.
REQ-039 rst asserted in SERVICE -> next cycle IDLE, in_service=0, pending=0, no int_load; a stray reti afterwards -> no output.
REQ-040 irq=4'b1111 held through and after reset, with boundaries applied -> no int_save.
